alu_exec_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_shift_step.sv | 25 ++
 rtl/alu_exec_unit.sv | 183 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the ALUops encoding (also used by the ALU control
// decoder), execute-stage FSM states and the default datapath width.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Numeric values are fixed by the decoder interface; do not reorder.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SRL  = 4'd3,
        OP_SRA  = 4'd4,
        OP_XOR  = 4'd5,
        OP_OR   = 4'd6,
        OP_AND  = 4'd7,
        OP_SLT  = 4'd8,
        OP_BEQ  = 4'd9,
        OP_BNE  = 4'd10,
        OP_BLT  = 4'd11,
        OP_BGE  = 4'd12,
        OP_BLTU = 4'd13,
        OP_BGEU = 4'd14,
        OP_SLTU = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } exec_state_e;

endpackage

// File: rtl/alu_shift_step.sv
// One step of the iterative shifter: shifts din by 0..SHIFT_STEP bits,
// left (zero fill) or right (zero or sign fill).
module alu_shift_step #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter int AMT_W      = $clog2(SHIFT_STEP + 1)
) (
    input  logic [XLEN-1:0]  din,
    input  logic [AMT_W-1:0] amt,
    input  logic             left,
    input  logic             arith,
    output logic [XLEN-1:0]  dout
);

    // The working value's MSB is still the original sign, so >>> replicates it.
    always_comb begin
        if (left)
            dout = din << amt;
        else if (arith)
            dout = $signed(din) >>> amt;
        else
            dout = din >> amt;
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage with valid/ready on both sides.
// Single-cycle add/logic/compare/branch; shifts are iterative (SHIFT_STEP
// bits per cycle) unless ALU_EXEC_BARREL_SHIFT_EN is defined, in which case
// shifts use a combinational barrel shifter and finish in one cycle.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int SHIFT_STEP = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [3:0]      ALUops,
    input  logic [XLEN-1:0] OP_A,
    input  logic [XLEN-1:0] OP_B,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] RESULT,
    output logic            BR_TAKEN
);

    localparam int SHAMT_W = $clog2(XLEN);

    exec_state_e     state;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic            br_q;
    alu_op_e         in_op;

    assign in_op     = alu_op_e'(ALUops);
    assign IN_READY  = (state == IDLE) & ~FLUSH;
    assign OUT_VALID = out_valid_q;
    assign RESULT    = result_q;
    assign BR_TAKEN  = br_q;

    // Single-cycle evaluation; returns {br_taken, result}.
    function automatic logic [XLEN:0] alu_eval(alu_op_e op, logic [XLEN-1:0] a,
                                               logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        logic            br;
        logic            lt, ltu, eq;
        r   = '0;
        br  = 1'b0;
        lt  = $signed(a) < $signed(b);
        ltu = a < b;
        eq  = a == b;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
            OP_SLL:  r = a << b[SHAMT_W-1:0];
            OP_SRL:  r = a >> b[SHAMT_W-1:0];
            OP_SRA:  r = $signed(a) >>> b[SHAMT_W-1:0];
`else
            // Only reached with a zero shift amount; nonzero goes iterative.
            OP_SLL, OP_SRL, OP_SRA: r = a;
`endif
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_SLT:  r = XLEN'(lt);
            OP_SLTU: r = XLEN'(ltu);
            OP_BEQ:  br = eq;
            OP_BNE:  br = ~eq;
            OP_BLT:  br = lt;
            OP_BGE:  br = ~lt;
            OP_BLTU: br = ltu;
            OP_BGEU: br = ~ltu;
            default: r = '0;
        endcase
        if (br)
            r = XLEN'(1'b1);
        return {br, r};
    endfunction

`ifndef ALU_EXEC_BARREL_SHIFT_EN
    localparam int AMT_W = $clog2(SHIFT_STEP + 1);
    localparam int CW    = SHAMT_W + 1;

    logic [XLEN-1:0]    work_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               left_q, arith_q;
    logic [AMT_W-1:0]   step_amt;
    logic [SHAMT_W-1:0] cnt_nxt;
    logic [XLEN-1:0]    step_out;
    logic               in_shift;

    assign in_shift = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);

    // Shift by min(SHIFT_STEP, remaining) this cycle.
    always_comb begin
        if ({1'b0, cnt_q} >= CW'(SHIFT_STEP))
            step_amt = AMT_W'(SHIFT_STEP);
        else
            step_amt = AMT_W'(cnt_q);
        cnt_nxt = cnt_q - SHAMT_W'(step_amt);
    end

    alu_shift_step #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP),
        .AMT_W      (AMT_W)
    ) u_step (
        .din   (work_q),
        .amt   (step_amt),
        .left  (left_q),
        .arith (arith_q),
        .dout  (step_out)
    );

    // Iterative shifter state: working value, remaining count, direction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            work_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (FLUSH) begin
            cnt_q   <= '0;
        end else if (state == IDLE && IN_VALID && in_shift) begin
            work_q  <= OP_A;
            cnt_q   <= OP_B[SHAMT_W-1:0];
            left_q  <= (in_op == OP_SLL);
            arith_q <= (in_op == OP_SRA);
        end else if (state == SHIFT) begin
            work_q  <= step_out;
            cnt_q   <= cnt_nxt;
        end
    end
`endif

    // Control FSM with registered result, branch flag and output valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            br_q        <= 1'b0;
        end else if (FLUSH) begin
            // RESULT intentionally keeps its last value.
            state       <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
`ifndef ALU_EXEC_BARREL_SHIFT_EN
                        if (in_shift && OP_B[SHAMT_W-1:0] != '0) begin
                            state <= SHIFT;
                        end else
`endif
                        begin
                            {br_q, result_q} <= alu_eval(in_op, OP_A, OP_B);
                            out_valid_q      <= 1'b1;
                            state            <= DONE;
                        end
                    end
                end
`ifndef ALU_EXEC_BARREL_SHIFT_EN
                SHIFT: begin
                    if (cnt_nxt == '0) begin
                        result_q    <= step_out;
                        br_q        <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (XLEN=32, SHIFT_STEP=1).
// Expected shift latencies follow ALU_EXEC_BARREL_SHIFT_EN when defined.
module tb_alu_exec_unit;

`ifdef ALU_EXEC_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        FLUSH = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [3:0]  ALUops = 4'd0;
    logic [31:0] OP_A = '0;
    logic [31:0] OP_B = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] RESULT;
    logic        BR_TAKEN;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    bit ready_low;
    bit seen;
    logic [31:0] held;

    always #5 CLK = ~CLK;

    alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .ALUops    (ALUops),
        .OP_A      (OP_A),
        .OP_B      (OP_B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESULT    (RESULT),
        .BR_TAKEN  (BR_TAKEN)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Wait for IN_READY, present one op, then wait for OUT_VALID.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int l);
        int g;
        g = 0;
        while (!IN_READY && g < 100) begin step(); g++; end
        if (g >= 100) chk("ready_timeout", 0, 1);
        ALUops = op; OP_A = a; OP_B = b; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        l = 1;
        ready_low = 1'b1;
        while (!OUT_VALID && l < 200) begin
            if (IN_READY) ready_low = 1'b0;
            step();
            l++;
        end
        if (!OUT_VALID) chk("valid_timeout", 0, 1);
    endtask

    task automatic take();
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
    endtask

    initial begin
        // Reset state
        #1 RST = 1'b1;
        #2;
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_result", RESULT, 0);
        chk("rst_br", BR_TAKEN, 0);
        #10 RST = 1'b0;
        step();
        chk("rst_in_ready", IN_READY, 1);

        // ADD wrap, SUB negative
        run_op(4'd0, 32'hFFFF_FFFF, 32'd1, lat);
        chk("add_res", RESULT, 32'h0);
        chk("add_lat", lat, 1);
        chk("add_br", BR_TAKEN, 0);
        take();
        run_op(4'd1, 32'd5, 32'd7, lat);
        chk("sub_res", RESULT, 32'hFFFF_FFFE);
        take();

        // SRA by 31
        run_op(4'd4, 32'h8000_0000, 32'd31, lat);
        chk("sra_res", RESULT, 32'hFFFF_FFFF);
        chk("sra_lat", lat, BARREL ? 1 : 32);
        chk("sra_in_ready_low", ready_low, 1);
        take();

        // SLL by 0, SLL by 31, SRL by 4
        run_op(4'd2, 32'h1234_5678, 32'd0, lat);
        chk("sll0_res", RESULT, 32'h1234_5678);
        chk("sll0_lat", lat, 1);
        take();
        run_op(4'd2, 32'h0000_0001, 32'd31, lat);
        chk("sll31_res", RESULT, 32'h8000_0000);
        take();
        run_op(4'd3, 32'hF000_0000, 32'h0000_0104, lat);
        chk("srl4_res", RESULT, 32'h0F00_0000);
        chk("srl4_lat", lat, BARREL ? 1 : 5);
        take();

        // Branches and set-less-than
        run_op(4'd11, 32'hFFFF_FFFF, 32'd1, lat);
        chk("blt_br", BR_TAKEN, 1);
        chk("blt_res", RESULT, 32'd1);
        take();
        run_op(4'd13, 32'hFFFF_FFFF, 32'd1, lat);
        chk("bltu_br", BR_TAKEN, 0);
        chk("bltu_res", RESULT, 32'd0);
        take();
        run_op(4'd9, 32'h1234, 32'h1234, lat);
        chk("beq_br", BR_TAKEN, 1);
        take();
        run_op(4'd12, 32'hFFFF_FFFF, 32'd1, lat);
        chk("bge_br", BR_TAKEN, 0);
        take();
        run_op(4'd15, 32'd1, 32'hFFFF_FFFF, lat);
        chk("sltu_res", RESULT, 32'd1);
        chk("sltu_br", BR_TAKEN, 0);
        take();
        run_op(4'd8, 32'd1, 32'hFFFF_FFFF, lat);
        chk("slt_res", RESULT, 32'd0);
        take();

        // Backpressure on XOR
        run_op(4'd5, 32'hFF00_FF00, 32'h0FF0_0FF0, lat);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", OUT_VALID, 1);
            chk("bp_res", RESULT, 32'hF0F0_F0F0);
            chk("bp_in_ready", IN_READY, 0);
            step();
        end
        take();
        chk("bp_idle_valid", OUT_VALID, 0);
        chk("bp_idle_ready", IN_READY, 1);
        run_op(4'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, lat);
        chk("and_res", RESULT, 32'h0F00_0F00);
        chk("and_lat", lat, 1);
        take();

`ifndef ALU_EXEC_BARREL_SHIFT_EN
        // FLUSH on the 4th SHIFT cycle of SRL by 20
        ALUops = 4'd3; OP_A = 32'hFFFF_FFFF; OP_B = 32'd20; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        chk("fl_accepted", IN_READY, 0);
        step(); step(); step();
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        #1;
        chk("fl_in_ready", IN_READY, 1);
        chk("fl_out_valid", OUT_VALID, 0);
        chk("fl_result_kept", RESULT, 32'h0F00_0F00);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (OUT_VALID) seen = 1'b1;
            step();
        end
        chk("fl_never_valid", seen, 0);
`else
        // FLUSH while holding a result in DONE
        run_op(4'd6, 32'h1, 32'h2, lat);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        #1;
        chk("fl_out_valid", OUT_VALID, 0);
        chk("fl_result_kept", RESULT, 32'h3);
`endif

        // FLUSH with IN_VALID in IDLE: no accept
        held = RESULT;
        ALUops = 4'd0; OP_A = 32'd10; OP_B = 32'd20; IN_VALID = 1'b1; FLUSH = 1'b1;
        #1;
        chk("fv_in_ready", IN_READY, 0);
        step();
        IN_VALID = 1'b0; FLUSH = 1'b0;
        #1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (OUT_VALID) seen = 1'b1;
            step();
        end
        chk("fv_no_accept", seen, 0);
        chk("fv_result_kept", RESULT, held);
        chk("fv_ready_after", IN_READY, 1);

        // Asynchronous RST mid-operation
        ALUops = 4'd3; OP_A = 32'hFFFF_FFFF; OP_B = 32'd20; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        step(); step();
        #2 RST = 1'b1;
        #1;
        chk("arst_out_valid", OUT_VALID, 0);
        chk("arst_result", RESULT, 0);
        #1 RST = 1'b0;
        step();
        chk("arst_in_ready", IN_READY, 1);
        run_op(4'd0, 32'd2, 32'd3, lat);
        chk("arst_next_op", RESULT, 32'd5);
        take();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global safety bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
